// File: rtl/fp_compare_stream.sv
// fp_compare_stream: per-lane floating-point compare of paired A/B operand streams, one result byte per lane.
// Latency: result is presented 2 cycles after the A/B beat is accepted; sustained rate 1 beat/cycle.
// Backpressure: two-stage valid/ready pipeline; input treadys drop only when both stages are full and the result is stalled.

module fp_compare_stream #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10,
   parameter int LANES = 1
) (
   input  logic                         clock,
   input  logic                         rst_n,
   input  logic [2:0]                   op,
   input  logic                         s_axis_a_tvalid,
   output logic                         s_axis_a_tready,
   input  logic [LANES*(1+EXP_W+MAN_W)-1:0] s_axis_a_tdata,
   input  logic                         s_axis_b_tvalid,
   output logic                         s_axis_b_tready,
   input  logic [LANES*(1+EXP_W+MAN_W)-1:0] s_axis_b_tdata,
   output logic                         m_axis_result_tvalid,
   input  logic                         m_axis_result_tready,
   output logic [LANES*8-1:0]           m_axis_result_tdata,
   output logic                         nan_seen,
   input  logic                         clear
);

   localparam int W     = 1 + EXP_W + MAN_W;
   localparam int MAG_W = EXP_W + MAN_W;

   localparam logic [2:0] OP_EQ    = 3'd0;
   localparam logic [2:0] OP_LT    = 3'd1;
   localparam logic [2:0] OP_LE    = 3'd2;
   localparam logic [2:0] OP_GT    = 3'd3;
   localparam logic [2:0] OP_GE    = 3'd4;
   localparam logic [2:0] OP_NE    = 3'd5;
   localparam logic [2:0] OP_UNORD = 3'd6;

   // Input-side classification, one bit per lane.
   logic [LANES-1:0] c_a_nan, c_b_nan, c_zero, c_a_sgn, c_b_sgn, c_mag_lt, c_mag_eq;

   // Stage 1: classification of the accepted beat plus its compare mode.
   logic             v1_q, v1_d;
   logic [2:0]       op1_q, op1_d;
   logic [LANES-1:0] a_nan_q, a_nan_d, b_nan_q, b_nan_d, zero_q, zero_d;
   logic [LANES-1:0] a_sgn_q, a_sgn_d, b_sgn_q, b_sgn_d, mag_lt_q, mag_lt_d, mag_eq_q, mag_eq_d;

   // Stage 2: result bytes.
   logic             v2_q, v2_d;
   logic [LANES*8-1:0] res_q, res_d;

   logic             nan_seen_q, nan_seen_d;
   logic             adv2, accept, fire;

   // Sign/magnitude split per lane; sign-magnitude ordering of {exp,man} is exact for normals, subnormals and infinities.
   for (genvar g = 0; g < LANES; g++) begin : g_cls
      logic [W-1:0]     a_w, b_w;
      logic [MAG_W-1:0] a_mag, b_mag;
      assign a_w          = s_axis_a_tdata[g*W +: W];
      assign b_w          = s_axis_b_tdata[g*W +: W];
      assign a_mag        = a_w[MAG_W-1:0];
      assign b_mag        = b_w[MAG_W-1:0];
      assign c_a_nan[g]   = (a_mag[MAG_W-1 -: EXP_W] == {EXP_W{1'b1}}) && (a_mag[MAN_W-1:0] != '0);
      assign c_b_nan[g]   = (b_mag[MAG_W-1 -: EXP_W] == {EXP_W{1'b1}}) && (b_mag[MAN_W-1:0] != '0);
      assign c_zero[g]    = (a_mag == '0) && (b_mag == '0);
      assign c_a_sgn[g]   = a_w[W-1];
      assign c_b_sgn[g]   = b_w[W-1];
      assign c_mag_lt[g]  = a_mag < b_mag;
      assign c_mag_eq[g]  = a_mag == b_mag;
   end

   // Condition outcome for one lane; +0/-0 fold to equal, unordered lanes only satisfy NE and UNORD.
   function automatic logic cond_out(input logic [2:0] o, input logic unord, input logic zero,
                                     input logic sa, input logic sb, input logic mlt, input logic meq);
      logic eq, lt, gt, r;
      eq = zero | ((sa == sb) & meq);
      if (zero)          lt = 1'b0;
      else if (sa != sb) lt = sa;
      else if (sa)       lt = ~mlt & ~meq;
      else               lt = mlt;
      gt = ~eq & ~lt;
      r  = 1'b0;
      if (unord) begin
         r = (o == OP_NE) | (o == OP_UNORD);
      end else begin
         case (o)
            OP_EQ:   r = eq;
            OP_LT:   r = lt;
            OP_LE:   r = lt | eq;
            OP_GT:   r = gt;
            OP_GE:   r = gt | eq;
            OP_NE:   r = ~eq;
            default: r = 1'b0;
         endcase
      end
      return r;
   endfunction

   // Handshake, stage advance and next-state for both pipeline stages and the sticky flag.
   always_comb begin
      adv2       = ~v2_q | m_axis_result_tready;
      accept     = ~v1_q | adv2;
      fire       = s_axis_a_tvalid & s_axis_b_tvalid & accept;
      v1_d       = v1_q;
      op1_d      = op1_q;
      a_nan_d    = a_nan_q;
      b_nan_d    = b_nan_q;
      zero_d     = zero_q;
      a_sgn_d    = a_sgn_q;
      b_sgn_d    = b_sgn_q;
      mag_lt_d   = mag_lt_q;
      mag_eq_d   = mag_eq_q;
      v2_d       = v2_q;
      res_d      = res_q;
      if (accept) begin
         v1_d = fire;
         if (fire) begin
            op1_d    = op;
            a_nan_d  = c_a_nan;
            b_nan_d  = c_b_nan;
            zero_d   = c_zero;
            a_sgn_d  = c_a_sgn;
            b_sgn_d  = c_b_sgn;
            mag_lt_d = c_mag_lt;
            mag_eq_d = c_mag_eq;
         end
      end
      if (adv2) begin
         v2_d = v1_q;
         if (v1_q) begin
            for (int i = 0; i < LANES; i++) begin
               res_d[i*8 +: 8] = {6'b0, a_nan_q[i] | b_nan_q[i],
                                  cond_out(op1_q, a_nan_q[i] | b_nan_q[i], zero_q[i], a_sgn_q[i],
                                           b_sgn_q[i], mag_lt_q[i], mag_eq_q[i])};
            end
         end
      end
      // Clear wins over a set landing in the same cycle.
      if (clear) nan_seen_d = 1'b0;
      else       nan_seen_d = nan_seen_q | (fire & (|(c_a_nan | c_b_nan)));
   end

   // Pipeline and flag registers; reset empties both stages and zeroes the result.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         v1_q       <= 1'b0;
         op1_q      <= 3'd0;
         a_nan_q    <= '0;
         b_nan_q    <= '0;
         zero_q     <= '0;
         a_sgn_q    <= '0;
         b_sgn_q    <= '0;
         mag_lt_q   <= '0;
         mag_eq_q   <= '0;
         v2_q       <= 1'b0;
         res_q      <= '0;
         nan_seen_q <= 1'b0;
      end else begin
         v1_q       <= v1_d;
         op1_q      <= op1_d;
         a_nan_q    <= a_nan_d;
         b_nan_q    <= b_nan_d;
         zero_q     <= zero_d;
         a_sgn_q    <= a_sgn_d;
         b_sgn_q    <= b_sgn_d;
         mag_lt_q   <= mag_lt_d;
         mag_eq_q   <= mag_eq_d;
         v2_q       <= v2_d;
         res_q      <= res_d;
         nan_seen_q <= nan_seen_d;
      end
   end

   // Each side's ready waits on the other side's valid so A and B are always consumed together.
   assign s_axis_a_tready      = rst_n & accept & s_axis_b_tvalid;
   assign s_axis_b_tready      = rst_n & accept & s_axis_a_tvalid;
   assign m_axis_result_tvalid = v2_q;
   assign m_axis_result_tdata  = res_q;
   assign nan_seen             = nan_seen_q;

endmodule
